fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the project FIFO among `NUM_REQ` independent producers. It sits between the producer blocks and the FIFO write-side pins. It throttles on full and almost-full so no write is ever issued into a full FIFO. It also checks each issued write against the FIFO's write acknowledge and overflow responses, and counts lost writes.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8
- `FIFO_WIDTH`, 16 — data width, equal to the FIFO data width
- `CNT_W`, 8 — width of the drop counter

- `clk` input 1 — single clock; all logic on the rising edge
- `rst` input 1 — synchronous, active-high reset
- `req` input `NUM_REQ` — per-requester write request, held until granted
- `req_data` input `NUM_REQ*FIFO_WIDTH` — requester i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH]
- `gnt` output `NUM_REQ` — registered one-hot pulse: requester's data accepted this cycle
- `fifo_wr_en` output 1 — registered write enable to FIFO
- `fifo_data_in` output `FIFO_WIDTH` — registered write data to FIFO
- `fifo_full` input 1 — FIFO full flag
- `fifo_almostfull` input 1 — FIFO has exactly one free slot
- `fifo_wr_ack` input 1 — FIFO write accepted, asserted the cycle after `fifo_wr_en`
- `fifo_overflow` input 1 — FIFO write rejected, asserted the cycle after `fifo_wr_en`
- `drop_cnt` output `CNT_W` — number of issued writes not acknowledged, saturating
- `wr_err` output 1 — sticky: at least one issued write was lost

## Operation
**Reset**
- While `rst` is high at a rising edge: `gnt`=0, `fifo_wr_en`=0, `fifo_data_in`=0, `drop_cnt`=0, `wr_err`=0, `pending`=0, and `last_grant`=`NUM_REQ`-1, so requester 0 has top priority after reset.
- Reset mid-operation discards any in-flight check. A write issued the cycle before reset is not counted.

**Eligibility** (combinational, current cycle)
- Requester i is eligible when `req[i]`=1 and `gnt[i]`=0.
- Masking on `gnt[i]` prevents re-granting a request that is still held in the grant cycle.

**Throttle**
- No issue when `fifo_full`=1.
- No issue when `fifo_almostfull`=1 and `fifo_wr_en`=1, because the in-flight write consumes the last slot.

**Arbitration**
- Search starts at `last_grant`+1 modulo `NUM_REQ`. The first eligible index wins.
- On issue, at the next rising edge:
  - `gnt[win]`=1
  - `fifo_wr_en`=1
  - `fifo_data_in`=req_data slice of `win`
  - `last_grant`=`win`
- Otherwise `gnt`=0 and `fifo_wr_en`=0; `fifo_data_in` holds its value.

**Requester rule**
- A requester whose `gnt` is high must deassert `req` or present new data in the following cycle.
- Each requester can win at most every other cycle. With two or more active requesters, the FIFO port can be written every cycle.

**Response checking**
- `pending` is a 1-bit register loaded with `fifo_wr_en` each cycle.
- When `pending`=1:
  - `fifo_wr_ack`=1 means the write succeeded.
  - `fifo_wr_ack`=0 or `fifo_overflow`=1 means the write was lost: `drop_cnt` increments (saturating at all-ones) and `wr_err` is set to 1.
- `fifo_wr_ack` or `fifo_overflow` while `pending`=0 are ignored.

## Timing
- Latency from request to grant is 1 cycle when uncontended and unthrottled: `req` sampled at edge t, `gnt`/`fifo_wr_en` high in cycle t..t+1.
- The check result lands 1 cycle after `fifo_wr_en`. `drop_cnt`/`wr_err` update at the following edge, 2 edges after the issue edge.
- Worst-case wait for a continuously requesting producer, with the FIFO not full, is `NUM_REQ`-1 grants to others.
- Simultaneous full and request: the throttle wins and `last_grant` is unchanged. Arbitration resumes the first cycle after the throttle clears, with no bubble beyond that.
- Pointer wrap: when `last_grant`=`NUM_REQ`-1, the search starts at index 0.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then `req`=4'b1111, data[i]=16'hA0+i, FIFO never full: grants follow the order 0,1,2,3,0,... every cycle; `fifo_data_in` sequence is 00A0,00A1,00A2,00A3; `drop_cnt`=0.
- Only `req[2]` held high continuously: `gnt[2]` pulses on alternate cycles, and `fifo_wr_en` is high on alternate cycles.
- `fifo_almostfull`=1 with one write in flight, `req`=4'b0011: no `fifo_wr_en` in the next cycle; `fifo_full`=1 blocks further writes; after `fifo_full` drops, requester 0 or 1 is granted per the pointer.
- Force `fifo_wr_ack`=0 and `fifo_overflow`=1 for three issued writes: `drop_cnt`=3 and `wr_err`=1. `wr_err` stays 1 after good acks resume; `drop_cnt` saturates at 255 after 300 forced drops.
- `rst`=1 for one cycle while `req`=4'b1111 and `last_grant`=1: next cycle all outputs are 0; the first post-reset grant is requester 0; the lost in-flight check is not counted.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the single FIFO write port
// among NUM_REQ producers. It throttles on full/almost-full and checks every
// issued write against the FIFO's ack/overflow response one cycle later,
// counting lost writes in a saturating counter and raising a sticky error flag.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic                          wr_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  fifo_wr_en_q, fifo_wr_en_d;
    logic [FIFO_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic                  wr_err_q, wr_err_d;
    logic                  pending_q, pending_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]    elig_s;
    logic                  throttle_s;
    logic                  win_found_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic [FIFO_WIDTH-1:0] win_data_s;
    logic                  issue_s;
    logic                  lost_s;

    // Eligibility and throttle: a held request already granted this cycle is
    // masked, and the in-flight write counts against an almost-full FIFO.
    always_comb begin
        elig_s     = req & ~gnt_q;
        throttle_s = fifo_full | (fifo_almostfull & fifo_wr_en_q);
    end

    // Rotating priority search starting just after the last winner.
    always_comb begin
        int cand;
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k + 32'sd1) % NUM_REQ;
            if (!win_found_s && elig_s[IDX_W'(cand)]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
        issue_s = win_found_s & ~throttle_s;
    end

    // Select the winner's data slice with constant-indexed slices.
    always_comb begin
        win_data_s = {FIFO_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == IDX_W'(i)) begin
                win_data_s = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Next-state for the write port: grant pulse, enable, data and pointer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = issue_s && (win_idx_s == IDX_W'(i));
        end
        fifo_wr_en_d = issue_s;
        if (issue_s) begin
            fifo_data_in_d = win_data_s;
            last_grant_d   = win_idx_s;
        end else begin
            fifo_data_in_d = fifo_data_in_q;
            last_grant_d   = last_grant_q;
        end
    end

    // Response check: the write issued last cycle must be acknowledged now.
    always_comb begin
        pending_d = fifo_wr_en_q;
        lost_s    = pending_q & (~fifo_wr_ack | fifo_overflow);
        if (lost_s && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        wr_err_d = wr_err_q | lost_s;
    end

    // State registers; reset points the pointer at the last index so that
    // requester 0 is searched first, and drops any in-flight check.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q          <= {NUM_REQ{1'b0}};
            fifo_wr_en_q   <= 1'b0;
            fifo_data_in_q <= {FIFO_WIDTH{1'b0}};
            drop_cnt_q     <= {CNT_W{1'b0}};
            wr_err_q       <= 1'b0;
            pending_q      <= 1'b0;
            last_grant_q   <= LAST_IDX;
        end else begin
            gnt_q          <= gnt_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_data_in_q <= fifo_data_in_d;
            drop_cnt_q     <= drop_cnt_d;
            wr_err_q       <= wr_err_d;
            pending_q      <= pending_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign gnt          = gnt_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_data_in = fifo_data_in_q;
    assign drop_cnt     = drop_cnt_q;
    assign wr_err       = wr_err_q;

endmodule
